// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - frog_cpu opcode constants and sequencer states
package frog_pkg;

   localparam logic [3:0] OP_NGA = 4'h0;
   localparam logic [3:0] OP_AND = 4'h1;
   localparam logic [3:0] OP_OR  = 4'h2;
   localparam logic [3:0] OP_XOR = 4'h3;
   localparam logic [3:0] OP_SLL = 4'h4;
   localparam logic [3:0] OP_SRL = 4'h5;
   localparam logic [3:0] OP_SRA = 4'h6;
   localparam logic [3:0] OP_ADD = 4'h7;
   localparam logic [3:0] OP_NOP = 4'h8;
   localparam logic [3:0] OP_BEQ = 4'h9;
   localparam logic [3:0] OP_BLE = 4'hA;
   localparam logic [3:0] OP_JMP = 4'hB;
   localparam logic [3:0] OP_LDA = 4'hC;
   localparam logic [3:0] OP_LDB = 4'hD;
   localparam logic [3:0] OP_STA = 4'hE;
   localparam logic [3:0] OP_STB = 4'hF;

   // F fetch, H/L operand nibbles, R load read, W store address, WD store data
   typedef enum logic [2:0] {
      ST_F,
      ST_H,
      ST_L,
      ST_R,
      ST_W,
      ST_WD
   } state_t;

endpackage

// File: rtl/frog_if.sv
// rtl/frog_if.sv - multiplexed address/data memory bus of frog_cpu
interface frog_if;
   logic [3:0] data_in;
   logic [6:0] daout;
   logic       wcyc;

   modport master (input data_in, output daout, output wcyc);
   modport slave  (output data_in, input daout, input wcyc);
endinterface

// File: rtl/frog_alu.sv
// rtl/frog_alu.sv - accumulator ALU and branch compare flags
module frog_alu
   import frog_pkg::*;
(
   input  logic [3:0] op,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] new_a,
   output logic       eq,
   output logic       le
);

   // Single-step accumulator result; non-ALU opcodes leave A untouched
   always_comb begin
      new_a = a;
      case (op)
         OP_NGA:  new_a = -a;
         OP_AND:  new_a = a & b;
         OP_OR:   new_a = a | b;
         OP_XOR:  new_a = a ^ b;
         OP_SLL:  new_a = {a[2:0], 1'b0};
         OP_SRL:  new_a = {1'b0, a[3:1]};
         OP_SRA:  new_a = {a[3], a[3:1]};
         OP_ADD:  new_a = a + b;
         default: new_a = a;
      endcase
   end

   assign eq = (a == b);
   assign le = (a <= b);

endmodule

// File: rtl/frog_cpu.sv
// rtl/frog_cpu.sv - 4-bit accumulator CPU with nibble-wide multiplexed memory bus
module frog_cpu
   import frog_pkg::*;
#(
   parameter int PRESCALE_LOG2 = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   fast,
   frog_if.master bus
);

   localparam logic [PRESCALE_LOG2-1:0] PRE_ONE = 1;

   state_t                   state_q, nxt_state;
   logic [6:0]               pc_q, nxt_pc;
   logic [3:0]               a_q, nxt_a;
   logic [3:0]               b_q, nxt_b;
   // Operand latch: bit 7 of the high nibble can never reach an address, so it is not kept
   logic [6:0]               t_q, nxt_t;
   logic [3:0]               ir_q, nxt_ir;
   logic [PRESCALE_LOG2-1:0] pre_q;
   logic [6:0]               daout_q;
   logic                     wcyc_q;

   logic [3:0] alu_a;
   logic       a_eq_b;
   logic       a_le_b;
   logic [6:0] br_tgt;
   logic       step;

   assign step   = fast | (&pre_q);
   assign br_tgt = {t_q[6:4], bus.data_in};

   frog_alu u_alu (
      .op    (bus.data_in),
      .a     (a_q),
      .b     (b_q),
      .new_a (alu_a),
      .eq    (a_eq_b),
      .le    (a_le_b)
   );

   // Bus word {wcyc, daout} that a given register set presents
   function automatic logic [7:0] bus_word(state_t s, logic [6:0] pc, logic [6:0] t,
                                           logic [3:0] a, logic [3:0] b, logic [3:0] ir);
      case (s)
         ST_R:    bus_word = {1'b0, t};
         ST_W:    bus_word = {1'b1, t};
         ST_WD:   bus_word = {1'b1, 3'b000, (ir == OP_STA) ? a : b};
         default: bus_word = {1'b0, pc};
      endcase
   endfunction

   // Next register values for one CPU step
   always_comb begin
      nxt_state = state_q;
      nxt_pc    = pc_q;
      nxt_a     = a_q;
      nxt_b     = b_q;
      nxt_t     = t_q;
      nxt_ir    = ir_q;
      case (state_q)
         ST_F: begin
            nxt_ir = bus.data_in;
            nxt_pc = pc_q + 7'd1;
            if (bus.data_in <= OP_NOP) begin
               nxt_a     = alu_a;
               nxt_state = ST_F;
            end else begin
               nxt_state = ST_H;
            end
         end
         ST_H: begin
            nxt_t[6:4] = bus.data_in[2:0];
            nxt_pc     = pc_q + 7'd1;
            nxt_state  = ST_L;
         end
         ST_L: begin
            nxt_t[3:0] = bus.data_in;
            nxt_pc     = pc_q + 7'd1;
            nxt_state  = ST_F;
            case (ir_q)
               OP_JMP:         nxt_pc = br_tgt;
               OP_BEQ:         if (a_eq_b) nxt_pc = br_tgt;
               OP_BLE:         if (a_le_b) nxt_pc = br_tgt;
               OP_LDA, OP_LDB: nxt_state = ST_R;
               OP_STA, OP_STB: nxt_state = ST_W;
               default:        nxt_state = ST_F;
            endcase
         end
         ST_R: begin
            if (ir_q == OP_LDA) nxt_a = bus.data_in;
            else                nxt_b = bus.data_in;
            nxt_state = ST_F;
         end
         ST_W:    nxt_state = ST_WD;
         ST_WD:   nxt_state = ST_F;
         default: nxt_state = ST_F;
      endcase
   end

   // Prescaler runs every clock; registers and the registered bus advance only on steps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_F;
         pc_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         t_q     <= '0;
         ir_q    <= '0;
         pre_q   <= '0;
         daout_q <= '0;
         wcyc_q  <= 1'b0;
      end else begin
         pre_q <= pre_q + PRE_ONE;
         if (step) begin
            state_q           <= nxt_state;
            pc_q              <= nxt_pc;
            a_q               <= nxt_a;
            b_q               <= nxt_b;
            t_q               <= nxt_t;
            ir_q              <= nxt_ir;
            {wcyc_q, daout_q} <= bus_word(nxt_state, nxt_pc, nxt_t, nxt_a, nxt_b, nxt_ir);
         end
      end
   end

   assign bus.daout = daout_q;
   assign bus.wcyc  = wcyc_q;

endmodule

// File: tb/tb_frog_cpu.sv
// tb/tb_frog_cpu.sv - scoreboard bench for frog_cpu bus sequences
module tb_frog_cpu;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic fast  = 1'b1;

   frog_if bus ();

   frog_cpu #(.PRESCALE_LOG2(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fast  (fast),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [3:0] mem [128];

   always_comb bus.data_in = bus.wcyc ? 4'h0 : mem[bus.daout];

   int         n_vec  = 0;
   int         n_miss = 0;
   logic [7:0] exp_q [$];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic ex(input logic [6:0] a);
      exp_q.push_back({1'b0, a});
   endtask

   task automatic exw(input logic [6:0] a);
      exp_q.push_back({1'b1, a});
   endtask

   task automatic exr(input logic [6:0] a, input int n);
      for (int i = 0; i < n; i++) ex(a + 7'(i));
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) mem[i] = 4'h8;
   endtask

   task automatic prog(input logic [6:0] base, input logic [255:0] code, input int n);
      for (int i = 0; i < n; i++) mem[base + 7'(i)] = code[4*(n-1-i) +: 4];
   endtask

   task automatic run(input string tag, input bit slow);
      logic [7:0] v;
      fast  = !slow;
      rst_n = 1'b0;
      @(negedge clk);
      chk({tag, "_rst"}, {bus.wcyc, bus.daout}, 8'h00);
      rst_n = 1'b1;
      while (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         for (int k = 0; k < (slow ? 4 : 1); k++) begin
            chk(tag, {bus.wcyc, bus.daout}, v);
            @(negedge clk);
         end
      end
   endtask

   task automatic load_lda_prog();
      clear_mem();
      prog(7'h02, 256'hC0D, 3);
      mem[7'h0D] = 4'h5;
      prog(7'h05, 256'hE30, 3);
      exr(7'h00, 5); ex(7'h0D); exr(7'h05, 3); exw(7'h30); exw(7'h05); ex(7'h08);
   endtask

   task automatic load_st_prog();
      clear_mem();
      prog(7'h00, 256'hC40_E20_F21, 9);
      mem[7'h40] = 4'h3;
   endtask

   initial begin
      logic found;

      // reset release into all-NOP memory: PC walks and wraps
      clear_mem();
      for (int i = 0; i < 128; i++) ex(7'(i));
      ex(7'h00);
      run("nop_walk", 1'b0);

      // LDA through an operand address, observed by a following STA
      load_lda_prog();
      run("lda", 1'b0);

      // ALU chain, each result exposed by STA 0x50
      clear_mem();
      prog(7'h00, 256'hC40_D41_0_E50_1_4_E50_C42_6_E50_C42_5_E50_C43_7_E50_2_E50_3_E50, 44);
      mem[7'h40] = 4'h5; mem[7'h41] = 4'h1; mem[7'h42] = 4'h8; mem[7'h43] = 4'hF;
      exr(7'h00, 3); ex(7'h40); exr(7'h03, 3); ex(7'h41); ex(7'h06);
      exr(7'h07, 3); exw(7'h50); exw(7'h0B);
      ex(7'h0A); ex(7'h0B);
      exr(7'h0C, 3); exw(7'h50); exw(7'h02);
      exr(7'h0F, 3); ex(7'h42); ex(7'h12);
      exr(7'h13, 3); exw(7'h50); exw(7'h0C);
      exr(7'h16, 3); ex(7'h42); ex(7'h19);
      exr(7'h1A, 3); exw(7'h50); exw(7'h04);
      exr(7'h1D, 3); ex(7'h43); ex(7'h20);
      exr(7'h21, 3); exw(7'h50); exw(7'h00);
      ex(7'h24);
      exr(7'h25, 3); exw(7'h50); exw(7'h01);
      ex(7'h28);
      exr(7'h29, 3); exw(7'h50); exw(7'h00);
      ex(7'h2C);
      run("alu", 1'b0);

      // branches: BEQ taken/untaken, BLE untaken/taken to 0x7E, JMP across wrap, JMP 2,0
      clear_mem();
      prog(7'h00, 256'h902_C40_902_AFE_D41_AFE, 18);
      mem[7'h40] = 4'h5; mem[7'h41] = 4'h7;
      mem[7'h7E] = 4'hB; mem[7'h7F] = 4'h2;
      prog(7'h29, 256'hB20, 3);
      exr(7'h00, 3); ex(7'h02);
      exr(7'h03, 3); ex(7'h40);
      exr(7'h06, 3);
      exr(7'h09, 3);
      exr(7'h0C, 3); ex(7'h41);
      exr(7'h0F, 3);
      exr(7'h7E, 2); ex(7'h00);
      exr(7'h29, 3);
      exr(7'h20, 2);
      run("branch", 1'b0);

      // STA then STB, two write steps each
      load_st_prog();
      exr(7'h00, 3); ex(7'h40);
      exr(7'h03, 3); exw(7'h20); exw(7'h03);
      exr(7'h06, 3); exw(7'h21); exw(7'h00);
      ex(7'h09);
      run("store", 1'b0);

      // prescaled stepping: every bus value held four clocks
      load_lda_prog();
      run("slow", 1'b1);

      // reset asserted during the store-address step
      load_st_prog();
      fast  = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if ({bus.wcyc, bus.daout} == 8'hA0) found = 1'b1;
      end
      chk("w_found", {7'b0, found}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      chk("w_async_rst", {bus.wcyc, bus.daout}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
